// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one SPI master among up to 8 requesters.
// Optional start/transfer timeouts are enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_xfer_scheduler #(
  parameter int NUM_REQ    = 8,
  parameter int GAP_CYCLES = 4,
  parameter int START_TMO  = 64,
  parameter int XFER_TMO   = 4096
) (
  input  logic               ACLK,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic [7:0]         spi_select,
  output logic               spi_start,
  input  logic               spi_busy,
  output logic               sched_idle
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_BUSY,
    S_DONE,
    S_GAP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               busy_m;
  logic               busy_s;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic               win_found;
  logic [NUM_REQ-1:0] grant_win;
  logic [GAP_W-1:0]   gap_cnt;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TMO_MAX = (START_TMO > XFER_TMO) ? START_TMO : XFER_TMO;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam logic [TMO_W-1:0] START_LAST = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] XFER_LAST  = TMO_W'(XFER_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_SAT    = {TMO_W{1'b1}};

  logic [TMO_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] err_q;
`endif

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    grant_win = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found       = 1'b1;
        win_idx         = cand;
        grant_win       = '0;
        grant_win[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (enable && |req) state_next = S_ARB;
      S_ARB:   state_next = win_found ? S_START : S_IDLE;
      S_START: begin
        if (busy_s) state_next = S_BUSY;
`ifdef SPI_SCHED_TIMEOUT_EN
        else if (tmo_cnt == START_LAST) state_next = S_GAP;
`endif
      end
      S_BUSY: begin
        if (!busy_s) state_next = S_DONE;
`ifdef SPI_SCHED_TIMEOUT_EN
        else if (tmo_cnt == XFER_LAST) state_next = S_GAP;
`endif
      end
      S_DONE:  state_next = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state   <= S_IDLE;
      busy_m  <= 1'b0;
      busy_s  <= 1'b0;
      ptr     <= PTR_W'(NUM_REQ - 1);
      grant   <= '0;
      gap_cnt <= '0;
    end else begin
      busy_m <= spi_busy;
      busy_s <= busy_m;
      state  <= state_next;
      if (state == S_ARB && win_found) begin
        grant <= grant_win;
        ptr   <= win_idx;
      end
      if (state == S_GAP && state_next == S_IDLE) grant <= '0;
      if (state != S_GAP) gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  // The timeout counter restarts on every state change, so it measures dwell time.
  always_ff @(posedge ACLK) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      if (state_next != state) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_SAT) tmo_cnt <= tmo_cnt + 1'b1;
      if ((state == S_START || state == S_BUSY) && state_next == S_GAP) err_q <= grant;
    end
  end

  assign err = err_q;
`else
  logic params_unused;
  assign params_unused = (START_TMO > 0) ^ (XFER_TMO > 0);
  assign err           = '0;
`endif

  assign done       = (state == S_DONE) ? grant : '0;
  assign spi_start  = (state == S_START);
  assign spi_select = 8'(grant);
  assign sched_idle = (state == S_IDLE);

endmodule
